// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: shared state encodings and handshake constants for the EX-stage divider
package ex_div_ctrl_pkg;

    localparam int RegBusW       = 32;
    localparam int DoubleRegBusW = 2 * RegBusW;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// div_step: one restoring shift-subtract iteration of the divider
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] low;

    assign shifted  = {rem, dividend_bit};
    assign low      = shifted[DATA_W-1:0];
    // the true difference is always below the divisor, so modulo-2^W subtraction of the low bits is exact
    assign q_bit    = shifted >= {1'b0, divisor};
    assign rem_next = q_bit ? low - divisor : low;

endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle restoring divide sequencer (DIV/DIVU) with pipeline stall and annul
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int DATA_W = RegBusW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    div_state_t          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   rem, rem_n;
    logic [DATA_W-1:0]   dvd, dvd_n;
    logic [DATA_W-1:0]   dsr, dsr_n;
    logic                neg_q, neg_q_n;
    logic                neg_r, neg_r_n;
    logic [2*DATA_W-1:0] result_n;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W-1:0]   step_rem;
    logic                step_q;
    logic [DATA_W-1:0]   q_final;

    // signed mode works on magnitudes; signs are reapplied when the result is formed
    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // dvd shifts dividend bits out of the top while quotient bits shift in at the bottom
    div_step #(.DATA_W(DATA_W)) u_step (
        .rem          (rem),
        .dividend_bit (dvd[DATA_W-1]),
        .divisor      (dsr),
        .rem_next     (step_rem),
        .q_bit        (step_q)
    );

    assign q_final    = {dvd[DATA_W-2:0], step_q};
    assign ready_o    = (state == DivEnd) ? DivResultReady : DivResultNotReady;
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    // next-state and datapath updates for the divide sequencer
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        dvd_n    = dvd;
        dsr_n    = dsr;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = result_o;
        case (state)
            DivFree: begin
                result_n = '0;
                if (start_i == DivStart && !annul_i) begin
                    dvd_n   = mag1;
                    dsr_n   = mag2;
                    rem_n   = '0;
                    cnt_n   = '0;
                    neg_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_r_n = signed_div_i & opdata1_i[DATA_W-1];
                    state_n = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                result_n = '0;
                state_n  = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_n = DivFree;
                end else begin
                    rem_n = step_rem;
                    dvd_n = q_final;
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state_n  = DivEnd;
                        result_n = {neg_r ? -step_rem : step_rem, neg_q ? -q_final : q_final};
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_n  = DivFree;
                    result_n = '0;
                end
            end
            default: state_n = DivFree;
        endcase
    end

    // state and datapath registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            dvd      <= dvd_n;
            dsr      <= dsr_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= result_n;
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: table, directed and randomized checks of the divide sequencer
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;

    ex_div_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: truncating division in 64-bit arithmetic; remainder follows the dividend sign
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // called one time unit after a rising edge; leaves start_i high with the result showing
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat, output logic stall_ok);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        #1;
        stall_ok = stallreq_o;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) break;
            if (!stallreq_o) stall_ok = 1'b0;
            if (lat == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
        end
        res = result_o;
    endtask

    task automatic release_div(input string name);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_clr_ready"}, {63'd0, ready_o}, 64'd0);
        chk({name, "_clr_result"}, result_o, 64'd0);
    endtask

    task automatic full_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input int exp_lat, input bit hold);
        logic [63:0] res;
        int          lat;
        logic        st_ok;
        run_div(s, a, b, res, lat, st_ok);
        chk({name, "_result"}, res, exp);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_stall_busy"}, {63'd0, st_ok}, 64'd1);
        chk({name, "_stall_done"}, {63'd0, stallreq_o}, 64'd0);
        if (hold) begin
            repeat (2) @(posedge clk);
            #1;
            chk({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            chk({name, "_hold_result"}, result_o, exp);
        end
        release_div(name);
    endtask

    task automatic watch_no_ready(input string name, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        chk({name, "_no_ready"}, {63'd0, seen}, 64'd0);
    endtask

    vec_t v[13];

    initial begin
        v[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        v[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
        v[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
        v[3]  = '{1'b0, 32'd5,          32'd0,          64'h0,                 2};
        v[4]  = '{1'b1, 32'd5,          32'd0,          64'h0,                 2};
        v[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
        v[6]  = '{1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF, 33};
        v[7]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 33};
        v[8]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33};
        v[9]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33};
        v[10] = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 33};
        v[11] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
        v[12] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33};

        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        #12;
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++)
            full_div($sformatf("vec%0d", i), v[i].s, v[i].a, v[i].b, v[i].exp, v[i].lat, i < 4);

        // annul during iteration 10, then a normal divide
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        chk("annul_on_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        watch_no_ready("annul_on", 40);
        full_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, 1'b0);

        // annul has priority over start in IDLE
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i = 1'b1;
        annul_i = 1'b1;
        #1;
        chk("idle_annul_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        watch_no_ready("idle_annul", 40);

        // annul while in BYZERO
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        watch_no_ready("byzero_annul", 5);

        // asynchronous reset in the middle of iteration 20
        opdata1_i = 32'd20000;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (21) @(posedge clk);
        #3;
        start_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_ready", {63'd0, ready_o}, 64'd0);
        chk("async_rst_result", result_o, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        watch_no_ready("after_rst", 40);
        full_div("after_rst_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);

        // randomized divides against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          k;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            k = $urandom_range(0, 7);
            b = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom_range(1, 15)) : (k == 2) ? 32'hFFFFFFFF : $urandom;
            full_div($sformatf("rnd%0d", i), s, a, b, model(s, a, b), (b == 32'd0) ? 2 : 33, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
